// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-cache arbiter, its three requesters and the cache port.
// slave = arbiter side, master = requester/cache side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              ld_req_in;
    logic [ADDR_W-1:0] ld_addr_in;
    logic [DATA_W-1:0] ld_data_in;
    logic              ld_gnt_out;

    logic              core_req_in;
    logic              core_we_in;
    logic [ADDR_W-1:0] core_addr_in;
    logic [DATA_W-1:0] core_data_in;
    logic              core_gnt_out;

    logic              rb_req_in;
    logic [ADDR_W-1:0] rb_addr_in;
    logic              rb_gnt_out;

    logic [DATA_W-1:0] rdata_out;
    logic              core_rvalid_out;
    logic              rb_rvalid_out;

    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_wen_out;
    logic [DATA_W-1:0] mem_data_in;
    logic              busy_out;

    modport slave (
        input  ld_req_in, ld_addr_in, ld_data_in,
        input  core_req_in, core_we_in, core_addr_in, core_data_in,
        input  rb_req_in, rb_addr_in,
        input  mem_data_in,
        output ld_gnt_out, core_gnt_out, rb_gnt_out,
        output rdata_out, core_rvalid_out, rb_rvalid_out,
        output mem_addr_out, mem_data_out, mem_wen_out, busy_out
    );

    modport master (
        output ld_req_in, ld_addr_in, ld_data_in,
        output core_req_in, core_we_in, core_addr_in, core_data_in,
        output rb_req_in, rb_addr_in,
        output mem_data_in,
        input  ld_gnt_out, core_gnt_out, rb_gnt_out,
        input  rdata_out, core_rvalid_out, rb_rvalid_out,
        input  mem_addr_out, mem_data_out, mem_wen_out, busy_out
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Three-way arbiter (loader > core > readback) for the single-port data cache.
// Optional macro DMEM_ARB_STARVE_EN promotes a starved readback requester.
//
// state     | meaning
// ----------+----------------------------------------------
// OWN_NONE  | IDLE: no access this cycle
// OWN_LD    | GRANT: loader write drives the cache port
// OWN_CORE  | GRANT: core read or write drives the cache port
// OWN_RB    | GRANT: readback read drives the cache port
module dmem_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int STARVE_LIM = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_CORE = 2'd2,
        OWN_RB   = 2'd3
    } owner_e;

    owner_e            owner_q, owner_d;
    logic              ld_elig, core_elig, rb_elig, rb_promote;
    logic              active, read_cap;
    logic              ld_gnt, core_gnt, rb_gnt, mem_wen;
    logic [ADDR_W-1:0] mem_addr, addr_hold_q, addr_hold_d;
    logic [DATA_W-1:0] mem_data, data_hold_q, data_hold_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              core_rvalid_q, core_rvalid_d, rb_rvalid_q, rb_rvalid_d;

    // A requester sits out the arbitration during its own grant cycle.
    assign ld_elig   = bus.ld_req_in   && (owner_q != OWN_LD);
    assign core_elig = bus.core_req_in && (owner_q != OWN_CORE);
    assign rb_elig   = bus.rb_req_in   && (owner_q != OWN_RB);

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIM);
    logic [3:0] rb_wait_q, rb_wait_d;

    assign rb_promote = rb_elig && (rb_wait_q >= STARVE_LIM_C);

    always_comb begin
        rb_wait_d = rb_wait_q;
        if (!bus.rb_req_in || (owner_d == OWN_RB)) begin
            rb_wait_d = '0;
        end else if (rb_elig && (rb_wait_q != 4'hF)) begin
            rb_wait_d = rb_wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_wait_q <= '0;
        end else begin
            rb_wait_q <= rb_wait_d;
        end
    end
`else
    assign rb_promote = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (rb_promote) begin
            owner_d = OWN_RB;
        end else if (ld_elig) begin
            owner_d = OWN_LD;
        end else if (core_elig) begin
            owner_d = OWN_CORE;
        end else if (rb_elig) begin
            owner_d = OWN_RB;
        end
    end

    // Reset in a grant cycle kills the access so nothing is committed.
    always_comb begin
        active   = (owner_q != OWN_NONE) && !rst;
        ld_gnt   = active && (owner_q == OWN_LD);
        core_gnt = active && (owner_q == OWN_CORE);
        rb_gnt   = active && (owner_q == OWN_RB);
        mem_addr = addr_hold_q;
        mem_data = data_hold_q;
        mem_wen  = 1'b0;
        read_cap = 1'b0;
        if (active) begin
            case (owner_q)
                OWN_LD: begin
                    mem_addr = bus.ld_addr_in;
                    mem_data = bus.ld_data_in;
                    mem_wen  = 1'b1;
                end
                OWN_CORE: begin
                    mem_addr = bus.core_addr_in;
                    mem_data = bus.core_data_in;
                    mem_wen  = bus.core_we_in;
                    read_cap = !bus.core_we_in;
                end
                OWN_RB: begin
                    mem_addr = bus.rb_addr_in;
                    read_cap = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        addr_hold_d   = mem_addr;
        data_hold_d   = mem_data;
        rdata_d       = read_cap ? bus.mem_data_in : rdata_q;
        core_rvalid_d = core_gnt && !bus.core_we_in;
        rb_rvalid_d   = rb_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold_q   <= '0;
            data_hold_q   <= '0;
            rdata_q       <= '0;
            core_rvalid_q <= 1'b0;
            rb_rvalid_q   <= 1'b0;
        end else begin
            addr_hold_q   <= addr_hold_d;
            data_hold_q   <= data_hold_d;
            rdata_q       <= rdata_d;
            core_rvalid_q <= core_rvalid_d;
            rb_rvalid_q   <= rb_rvalid_d;
        end
    end

    assign bus.ld_gnt_out      = ld_gnt;
    assign bus.core_gnt_out    = core_gnt;
    assign bus.rb_gnt_out      = rb_gnt;
    assign bus.busy_out        = active;
    assign bus.mem_addr_out    = mem_addr;
    assign bus.mem_data_out    = mem_data;
    assign bus.mem_wen_out     = mem_wen;
    assign bus.rdata_out       = rdata_q;
    assign bus.core_rvalid_out = core_rvalid_q;
    assign bus.rb_rvalid_out   = rb_rvalid_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-scenario tasks with inline checks,
// plus a read scoreboard popped whenever an rvalid appears.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic mem_load;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .STARVE_LIM(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] cache   [16];
    logic [7:0] exp_mem [16];

    typedef struct packed {
        logic       is_rb;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Cache fixture: combinational read, write on the clock edge.
    assign bus.mem_data_in = cache[bus.mem_addr_out];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) cache[i] <= 8'(i * 17 + 3);
        end else if (bus.mem_wen_out) begin
            cache[bus.mem_addr_out] <= bus.mem_data_out;
        end
    end

    // Scoreboard: every read result must match the oldest outstanding read.
    always @(negedge clk) begin
        rd_exp_t e;
        if (rst === 1'b0 && (bus.core_rvalid_out || bus.rb_rvalid_out)) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got rvalid core=%0b rb=%0b data=%h, required no read result",
                         bus.core_rvalid_out, bus.rb_rvalid_out, bus.rdata_out);
            end else begin
                e = sb_q.pop_front();
                if (bus.rb_rvalid_out !== e.is_rb || bus.core_rvalid_out !== !e.is_rb ||
                    bus.rdata_out !== e.data) begin
                    $display("FAIL sb_read: got core=%0b rb=%0b data=%h, required rb=%0b data=%h",
                             bus.core_rvalid_out, bus.rb_rvalid_out, bus.rdata_out, e.is_rb, e.data);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] gnts();
        return {bus.ld_gnt_out, bus.core_gnt_out, bus.rb_gnt_out};
    endfunction

    function automatic logic [26:0] all_outs();
        return {bus.ld_gnt_out, bus.core_gnt_out, bus.rb_gnt_out, bus.core_rvalid_out,
                bus.rb_rvalid_out, bus.mem_wen_out, bus.busy_out, bus.mem_addr_out,
                bus.mem_data_out, bus.rdata_out};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        mem_load = 1'b1;
        step();
        step();
        #2;
        n_checks++;
        if (all_outs() !== '0) $display("FAIL reset_outputs: got %h, required 0", all_outs());
        else n_pass++;
        rst = 1'b0;
        mem_load = 1'b0;
        step();
        #2;
        n_checks++;
        if (all_outs() !== '0) $display("FAIL post_reset_idle: got %h, required 0", all_outs());
        else n_pass++;
    endtask

    task automatic test_single_write();
        step();
        bus.core_req_in = 1'b1; bus.core_we_in = 1'b1;
        bus.core_addr_in = 4'd3; bus.core_data_in = 8'h5A;
        #2;
        n_checks++;
        if (bus.busy_out !== 1'b0) $display("FAIL wr_cycle0_busy: got %0b, required 0", bus.busy_out);
        else n_pass++;
        step();
        #2;
        n_checks++;
        if ({gnts(), bus.mem_wen_out, bus.mem_addr_out, bus.mem_data_out} !== {3'b010, 1'b1, 4'd3, 8'h5A})
            $display("FAIL wr_grant: got gnt=%b wen=%0b addr=%0d data=%h, required gnt=010 wen=1 addr=3 data=5a",
                     gnts(), bus.mem_wen_out, bus.mem_addr_out, bus.mem_data_out);
        else n_pass++;
        exp_mem[3] = 8'h5A;
        step();
        bus.core_we_in = 1'b0;
        sb_q.push_back('{is_rb: 1'b0, data: exp_mem[3]});
        #2;
        n_checks++;
        if (gnts() !== 3'b000) $display("FAIL rd_cycle0_gnt: got %b, required 000", gnts());
        else n_pass++;
        step();
        #2;
        n_checks++;
        if ({gnts(), bus.mem_wen_out, bus.mem_addr_out} !== {3'b010, 1'b0, 4'd3})
            $display("FAIL rd_grant: got gnt=%b wen=%0b addr=%0d, required gnt=010 wen=0 addr=3",
                     gnts(), bus.mem_wen_out, bus.mem_addr_out);
        else n_pass++;
        step();
        bus.core_req_in = 1'b0;
        #2;
        n_checks++;
        if (bus.core_rvalid_out !== 1'b1 || bus.rdata_out !== 8'h5A)
            $display("FAIL rd_result: got rvalid=%0b data=%h, required rvalid=1 data=5a",
                     bus.core_rvalid_out, bus.rdata_out);
        else n_pass++;
        step();
    endtask

    task automatic test_priority();
        logic [2:0] prev_g, g, exp_g;
        step();
        bus.ld_req_in = 1'b1; bus.ld_addr_in = 4'd1; bus.ld_data_in = 8'h11;
        bus.core_req_in = 1'b1; bus.core_we_in = 1'b0; bus.core_addr_in = 4'd2;
        bus.rb_req_in = 1'b1; bus.rb_addr_in = 4'd4;
        sb_q.push_back('{is_rb: 1'b0, data: exp_mem[2]});
        sb_q.push_back('{is_rb: 1'b1, data: exp_mem[4]});
        exp_mem[1] = 8'h11;
        #2;
        n_checks++;
        if (gnts() !== 3'b000) $display("FAIL prio_cycle0: got %b, required 000", gnts());
        else n_pass++;
        prev_g = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (prev_g[2]) bus.ld_req_in = 1'b0;
            if (prev_g[1]) bus.core_req_in = 1'b0;
            if (prev_g[0]) bus.rb_req_in = 1'b0;
            #2;
            g = gnts();
            case (k)
                1: exp_g = 3'b100;
                2: exp_g = 3'b010;
                3: exp_g = 3'b001;
                default: exp_g = 3'b000;
            endcase
            n_checks++;
            if (g !== exp_g) $display("FAIL prio_gnt_c%0d: got %b, required %b", k, g, exp_g);
            else n_pass++;
            if (k == 1) begin
                n_checks++;
                if ({bus.mem_wen_out, bus.mem_addr_out, bus.mem_data_out} !== {1'b1, 4'd1, 8'h11})
                    $display("FAIL prio_ld_port: got wen=%0b addr=%0d data=%h, required 1/1/11",
                             bus.mem_wen_out, bus.mem_addr_out, bus.mem_data_out);
                else n_pass++;
            end
            if (k == 3) begin
                n_checks++;
                if ({bus.core_rvalid_out, bus.mem_addr_out} !== {1'b1, 4'd4})
                    $display("FAIL prio_c3: got core_rvalid=%0b addr=%0d, required 1 and 4",
                             bus.core_rvalid_out, bus.mem_addr_out);
                else n_pass++;
            end
            if (k == 4) begin
                n_checks++;
                if ({bus.rb_rvalid_out, bus.mem_addr_out, bus.mem_wen_out} !== {1'b1, 4'd4, 1'b0})
                    $display("FAIL prio_c4: got rb_rvalid=%0b addr=%0d wen=%0b, required 1/4/0",
                             bus.rb_rvalid_out, bus.mem_addr_out, bus.mem_wen_out);
                else n_pass++;
            end
            prev_g = g;
        end
        step();
    endtask

    task automatic test_starvation();
        logic [2:0] prev_g, g, exp_g;
        step();
        bus.ld_req_in = 1'b1; bus.ld_addr_in = 4'd6; bus.ld_data_in = 8'h66;
        bus.core_req_in = 1'b1; bus.core_we_in = 1'b1; bus.core_addr_in = 4'd7; bus.core_data_in = 8'h77;
        bus.rb_req_in = 1'b1; bus.rb_addr_in = 4'd5;
        exp_mem[6] = 8'h66;
        exp_mem[7] = 8'h77;
`ifdef DMEM_ARB_STARVE_EN
        sb_q.push_back('{is_rb: 1'b1, data: exp_mem[5]});
`endif
        #2;
        prev_g = 3'b000;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (prev_g[0]) bus.rb_req_in = 1'b0;
            #2;
            g = gnts();
`ifdef DMEM_ARB_STARVE_EN
            if (k == 5) exp_g = 3'b001;
            else if (k < 5) exp_g = (k % 2 == 1) ? 3'b100 : 3'b010;
            else exp_g = (k % 2 == 0) ? 3'b100 : 3'b010;
`else
            exp_g = (k % 2 == 1) ? 3'b100 : 3'b010;
`endif
            n_checks++;
            if (g !== exp_g) $display("FAIL starve_gnt_c%0d: got %b, required %b", k, g, exp_g);
            else n_pass++;
            prev_g = g;
        end
        step();
        bus.ld_req_in = 1'b0;
        bus.core_req_in = 1'b0;
        bus.rb_req_in = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        step();
        bus.ld_req_in = 1'b1; bus.ld_addr_in = 4'd9; bus.ld_data_in = 8'hEE;
        #2;
        step();
        rst = 1'b1;
        #2;
        n_checks++;
        if (bus.mem_wen_out !== 1'b0) $display("FAIL rstmid_wen: got %0b, required 0", bus.mem_wen_out);
        else n_pass++;
        step();
        rst = 1'b0;
        bus.ld_req_in = 1'b0;
        #2;
        n_checks++;
        if (all_outs() !== '0) $display("FAIL rstmid_outputs: got %h, required 0", all_outs());
        else n_pass++;
        n_checks++;
        if (cache[9] !== exp_mem[9]) $display("FAIL rstmid_cache: got %h, required %h", cache[9], exp_mem[9]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        step();
        bus.core_req_in = 1'b1; bus.core_we_in = 1'b0; bus.core_addr_in = 4'd0;
        sb_q.push_back('{is_rb: 1'b0, data: exp_mem[0]});
        #2;
        step();
        #2;
        n_checks++;
        if ({gnts(), bus.mem_addr_out} !== {3'b010, 4'd0})
            $display("FAIL b2b_first: got gnt=%b addr=%0d, required 010 and 0", gnts(), bus.mem_addr_out);
        else n_pass++;
        step();
        bus.core_addr_in = 4'd1;
        sb_q.push_back('{is_rb: 1'b0, data: exp_mem[1]});
        #2;
        n_checks++;
        if (gnts() !== 3'b000) $display("FAIL b2b_gap: got %b, required 000", gnts());
        else n_pass++;
        step();
        #2;
        n_checks++;
        if ({gnts(), bus.mem_addr_out, bus.rdata_out} !== {3'b010, 4'd1, exp_mem[0]})
            $display("FAIL b2b_second: got gnt=%b addr=%0d rdata=%h, required 010/1/%h",
                     gnts(), bus.mem_addr_out, bus.rdata_out, exp_mem[0]);
        else n_pass++;
        step();
        bus.core_req_in = 1'b0;
        #2;
        n_checks++;
        if (bus.rdata_out !== exp_mem[1]) $display("FAIL b2b_rdata: got %h, required %h", bus.rdata_out, exp_mem[1]);
        else n_pass++;
        step();
    endtask

    task automatic test_idle();
        logic [4:0] v;
        for (int k = 0; k < 20; k++) begin
            step();
            #2;
            v = {gnts(), bus.mem_wen_out, bus.busy_out};
            n_checks++;
            if (v !== 5'b0 || bus.core_rvalid_out !== 1'b0 || bus.rb_rvalid_out !== 1'b0)
                $display("FAIL idle_c%0d: got gnt/wen/busy=%b rvalid=%0b%0b, required all 0",
                         k, v, bus.core_rvalid_out, bus.rb_rvalid_out);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_load = 1'b1;
        bus.ld_req_in = 1'b0; bus.ld_addr_in = '0; bus.ld_data_in = '0;
        bus.core_req_in = 1'b0; bus.core_we_in = 1'b0; bus.core_addr_in = '0; bus.core_data_in = '0;
        bus.rb_req_in = 1'b0; bus.rb_addr_in = '0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'(i * 17 + 3);

        test_reset();
        test_single_write();
        test_priority();
        test_starvation();
        test_reset_mid();
        test_back_to_back();
        test_idle();

        step();
        #2;
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL sb_drained: got %0d outstanding reads, required 0", sb_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
